cdf_accumulate_stream: RTL

- Parametrised running-sum (CDF) stage for the histogram-equalisation pipeline. Sits between the histogram readout and the CDF normalise/LUT stage.
- Takes one histogram bin count per valid beat. Emits the cumulative sum for that bin with its store address.
- Tracks the first non-zero CDF value (cdf_min) and the frame total.
- Tolerates gaps between beats, frame abort, back-to-back frames, bin-count checking and overflow detection.

---
 rtl/cdf_accumulate_stream_if.sv | 27 ++
 rtl/cdf_accumulate_stream.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cdf_accumulate_stream_if.sv
// Beat bus for the CDF running-sum stage: histogram bins in, cumulative values out.
// The stage is the slave; the histogram readout and the downstream LUT stage form the master side.
interface cdf_accumulate_stream_if #(
    parameter int IN_W   = 20,
    parameter int ACC_W  = 20,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [IN_W-1:0]   in_count;
    logic [ADDR_W-1:0] in_addr;
    logic              in_last;

    logic              out_valid;
    logic [ACC_W-1:0]  out_cdf;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output in_valid, in_count, in_addr, in_last,
        input  out_valid, out_cdf, out_addr, out_last
    );

    modport slave (
        input  in_valid, in_count, in_addr, in_last,
        output out_valid, out_cdf, out_addr, out_last
    );
endinterface

// File: rtl/cdf_accumulate_stream.sv
// Running-sum (CDF) of histogram bins with cdf_min / frame total tracking; CDF_ACCUM_SATURATE_EN selects saturating sums.
// Latency: 1 cycle from accepted beat to out_*.
// Backpressure: none; every valid beat is accepted, gaps hold state, frame_abort drops the same-cycle beat.
module cdf_accumulate_stream #(
    parameter int IN_W     = 20,
    parameter int ACC_W    = 20,
    parameter int ADDR_W   = 16,
    parameter int NUM_BINS = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    cdf_accumulate_stream_if.slave bus,
    input  logic                   frame_abort,
    output logic [ACC_W-1:0]       cdf_min,
    output logic                   cdf_min_valid,
    output logic [ACC_W-1:0]       cdf_total,
    output logic                   frame_done,
    output logic                   bin_error,
    output logic                   overflow
);

    // One code beyond NUM_BINS is needed so the over-length count can saturate there.
    localparam int CNT_W = $clog2(NUM_BINS + 2);
    localparam logic [CNT_W-1:0] NB      = CNT_W'(NUM_BINS);
    localparam logic [CNT_W-1:0] NB_OVER = CNT_W'(NUM_BINS + 1);

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] bin_cnt;

    logic             first_beat;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] sum_result;
    logic [CNT_W-1:0] cnt_next;
    logic             beat_err;
    logic             berr_next;
    logic             ovf_next;
    logic [ACC_W-1:0] min_base;
    logic             min_capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        first_beat = (state == S_IDLE);
        base       = first_beat ? '0 : acc;
        sum        = {1'b0, base} + (ACC_W + 1)'(bus.in_count);
        carry      = sum[ACC_W];
`ifdef CDF_ACCUM_SATURATE_EN
        sum_result = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        sum_result = sum[ACC_W-1:0];
`endif
        if (first_beat) begin
            cnt_next = CNT_W'(1);
        end else if (bin_cnt >= NB_OVER) begin
            cnt_next = NB_OVER;
        end else begin
            cnt_next = bin_cnt + 1'b1;
        end
        beat_err = bus.in_last ? (cnt_next != NB) : (cnt_next > NB);

        // Per-frame sticky state restarts on the first beat, before this beat's update.
        berr_next   = (first_beat ? 1'b0 : bin_error) | beat_err;
        ovf_next    = (first_beat ? 1'b0 : overflow) | carry;
        min_base    = first_beat ? '0 : cdf_min;
        min_capture = (min_base == '0) && (sum_result != '0);

        if (frame_abort) begin
            state_next = S_IDLE;
        end else if (bus.in_valid) begin
            state_next = bus.in_last ? S_IDLE : S_ACCUM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc           <= '0;
            bin_cnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_cdf   <= '0;
            bus.out_addr  <= '0;
            bus.out_last  <= 1'b0;
            cdf_min       <= '0;
            cdf_min_valid <= 1'b0;
            cdf_total     <= '0;
            frame_done    <= 1'b0;
            bin_error     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            frame_done    <= 1'b0;
            cdf_min_valid <= 1'b0;
            if (frame_abort) begin
                acc     <= '0;
                bin_cnt <= '0;
            end else if (bus.in_valid) begin
                acc           <= sum_result;
                bin_cnt       <= cnt_next;
                bus.out_valid <= 1'b1;
                bus.out_cdf   <= sum_result;
                bus.out_addr  <= bus.in_addr;
                bus.out_last  <= bus.in_last;
                bin_error     <= berr_next;
                overflow      <= ovf_next;
                cdf_min       <= min_capture ? sum_result : min_base;
                cdf_min_valid <= min_capture;
                if (bus.in_last) begin
                    frame_done <= 1'b1;
                    cdf_total  <= sum_result;
                end
            end
        end
    end

endmodule
